// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding and
// the default idle-timeout derived from the oversampling rate.
package uart_rx_ctrl_pkg;

  localparam int unsigned TICKS_PER_BIT      = 32;
  localparam int unsigned DEFAULT_IDLE_TICKS = 10 * TICKS_PER_BIT;

  typedef enum logic [3:0] {
    S_OFF    = 4'b0001,
    S_RUN    = 4'b0010,
    S_HOLD   = 4'b0100,
    S_FINISH = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundles the uart_rx-facing handshake and the byte-consumer valid/ready stream.
// The controller is the master; the receiver and the consumer sit on the slave side.
interface uart_rx_ctrl_if;

  logic       rx_enable;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_busy;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output rx_enable, data, valid,
    input  rx_data, rx_strobe, rx_busy, ready
  );

  modport slave (
    input  rx_enable, data, valid,
    output rx_data, rx_strobe, rx_busy, ready
  );

endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// First-word-fall-through synchronous byte FIFO: the head entry is read
// combinationally so a pushed byte is visible the cycle after the push.
module uart_rx_ctrl_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned    DEPTH   = 1 << AW;
  localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   level_next;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (level_reg == DEPTH_L);
  assign o_empty = (level_reg == '0);
  assign pop_ok  = i_pop & ~o_empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = i_push & (~o_full | pop_ok);

  always_comb begin
    level_next = level_reg;
    unique case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  assign o_data  = mem[rd_ptr_reg];
  assign o_level = level_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates uart_rx, buffers strobed bytes in a FWFT FIFO,
// flags overrun. Optional end-of-message pulse under `UART_RX_IDLE_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned IDLE_TICKS    = DEFAULT_IDLE_TICKS,
  parameter int unsigned IDLE_CNT_SIZE = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  uart_rx_ctrl_if.master       bus,
  output logic [FIFO_AW:0]     o_level,
  output logic                 o_overrun,
  input  logic                 i_clear_overrun,
  output logic                 o_idle
);

  rx_state_e  state_reg;
  rx_state_e  state_next;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       capture_en;
  logic       push;
  logic       pop;
  logic       drop;
  logic       overrun_reg;
  logic       overrun_next;

  // Strobes are honoured in every state but S_OFF so an in-flight frame is never lost.
  assign capture_en = bus.rx_strobe & (state_reg != S_OFF);
  assign pop        = bus.valid & bus.ready;
  assign push       = capture_en & (~fifo_full | pop);
  assign drop       = capture_en & fifo_full & ~pop;

  uart_rx_ctrl_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (bus.rx_data),
    .i_pop   (pop),
    .o_data  (fifo_rdata),
    .o_level (o_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign bus.valid = ~fifo_empty;
  assign bus.data  = fifo_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= S_OFF;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_OFF:    if (i_enable) state_next = S_RUN;
      S_RUN: begin
        if (!i_enable)                      state_next = S_FINISH;
        else if (fifo_full && !bus.rx_busy) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!i_enable)      state_next = S_OFF;
        else if (!fifo_full) state_next = S_RUN;
      end
      S_FINISH: if (!bus.rx_busy && !bus.rx_strobe) state_next = S_OFF;
      default:  state_next = S_OFF;
    endcase
  end

  always_comb begin
    bus.rx_enable = 1'b0;
    if (state_reg == S_RUN) bus.rx_enable = 1'b1;
  end

  // A drop in the same cycle as a clear request leaves the flag set.
  always_comb begin
    overrun_next = overrun_reg;
    if (drop)                 overrun_next = 1'b1;
    else if (i_clear_overrun) overrun_next = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) overrun_reg <= 1'b0;
    else       overrun_reg <= overrun_next;
  end

  assign o_overrun = overrun_reg;

`ifdef UART_RX_IDLE_TIMEOUT_EN
  localparam logic [IDLE_CNT_SIZE-1:0] IDLE_LAST = IDLE_CNT_SIZE'(IDLE_TICKS - 1);
  localparam logic [IDLE_CNT_SIZE-1:0] IDLE_MAX  = IDLE_CNT_SIZE'(IDLE_TICKS);

  logic [IDLE_CNT_SIZE-1:0] idle_cnt_reg;
  logic [IDLE_CNT_SIZE-1:0] idle_cnt_next;
  logic                     idle_arm_reg;
  logic                     idle_arm_next;
  logic                     idle_hit;

  // The pulse fires in the cycle the count reaches IDLE_TICKS and disarms itself,
  // so a silent line yields exactly one pulse per burst of received bytes.
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    idle_arm_next = idle_arm_reg;
    idle_hit      = 1'b0;
    if (state_reg == S_OFF) begin
      idle_cnt_next = '0;
      idle_arm_next = 1'b0;
    end else if (bus.rx_strobe || bus.rx_busy) begin
      idle_cnt_next = '0;
      if (push) idle_arm_next = 1'b1;
    end else if (idle_arm_reg) begin
      if (idle_cnt_reg == IDLE_LAST) begin
        idle_hit      = 1'b1;
        idle_arm_next = 1'b0;
      end
      if (idle_cnt_reg != IDLE_MAX) idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_cnt_reg <= '0;
      idle_arm_reg <= 1'b0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
      idle_arm_reg <= idle_arm_next;
    end
  end

  assign o_idle = idle_hit;
`else
  // Idle parameters have no consumer in this build; this block only names them.
  if (IDLE_TICKS >= (1 << IDLE_CNT_SIZE)) begin : g_idle_cfg_unused
  end

  assign o_idle = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: emulates uart_rx busy/strobe framing and
// compares the DUT each cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH     = 16;
  localparam int FRAME_CYC = 10;
  localparam int IDLE_T    = 320;
  localparam int M_OFF = 0, M_RUN = 1, M_HOLD = 2, M_FIN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear_ovr;
  logic [4:0] level;
  logic       overrun;
  logic       idle;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(
    .FIFO_AW       (4),
    .IDLE_TICKS    (IDLE_T),
    .IDLE_CNT_SIZE (9)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .bus             (bus),
    .o_level         (level),
    .o_overrun       (overrun),
    .i_clear_overrun (clear_ovr),
    .o_idle          (idle)
  );

  always #5 clk = ~clk;

  logic [7:0] m_q[$];
  bit         m_ovr;
  int         m_st;
  logic [7:0] beat_q[$];
  int         vectors;
  int         errors;
  int         cycles;
  int         max_lvl_seen;
  bit         rand_ready;

  // One clock: check outputs before the edge, advance the model, then step the DUT.
  task automatic tick();
    int lvl;
    bit pop, acc, drop;
    if (rand_ready) bus.ready = 1'($urandom_range(0, 1));
    #0;
    lvl = m_q.size();
    vectors++;
    if (bus.valid !== (lvl > 0)) begin
      errors++; $display("FAIL valid: got %b expected %b (cycle %0d)", bus.valid, lvl > 0, cycles);
    end
    if (lvl > 0) begin
      vectors++;
      if (bus.data !== m_q[0]) begin
        errors++; $display("FAIL data: got %02h expected %02h (cycle %0d)", bus.data, m_q[0], cycles);
      end
    end
    vectors++;
    if (level !== 5'(lvl)) begin
      errors++; $display("FAIL level: got %0d expected %0d (cycle %0d)", level, lvl, cycles);
    end
    vectors++;
    if (overrun !== m_ovr) begin
      errors++; $display("FAIL overrun: got %b expected %b (cycle %0d)", overrun, m_ovr, cycles);
    end
    vectors++;
    if (bus.rx_enable !== (m_st == M_RUN)) begin
      errors++; $display("FAIL rx_enable: got %b expected %b (cycle %0d)", bus.rx_enable, m_st == M_RUN, cycles);
    end
`ifndef UART_RX_IDLE_TIMEOUT_EN
    vectors++;
    if (idle !== 1'b0) begin
      errors++; $display("FAIL idle_off: got %b expected 0 (cycle %0d)", idle, cycles);
    end
`endif
    if (bus.valid === 1'b1 && bus.ready === 1'b1) beat_q.push_back(bus.data);

    pop  = bus.ready && lvl > 0;
    acc  = (m_st != M_OFF);
    drop = 1'b0;
    if (rst) begin
      m_q.delete(); m_ovr = 1'b0; m_st = M_OFF;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (bus.rx_strobe && acc) begin
        if (lvl < DEPTH || pop) m_q.push_back(bus.rx_data);
        else drop = 1'b1;
      end
      if (drop) m_ovr = 1'b1;
      else if (clear_ovr) m_ovr = 1'b0;
      case (m_st)
        M_OFF:  if (enable) m_st = M_RUN;
        M_RUN:  if (!enable) m_st = M_FIN; else if (lvl == DEPTH && !bus.rx_busy) m_st = M_HOLD;
        M_HOLD: if (!enable) m_st = M_OFF; else if (lvl < DEPTH) m_st = M_RUN;
        default: if (!bus.rx_busy && !bus.rx_strobe) m_st = M_OFF;
      endcase
    end

    @(posedge clk);
    #1;
    cycles++;
    if (int'(level) > max_lvl_seen) max_lvl_seen = int'(level);
    if (cycles > 40000) begin
      errors++;
      $display("FAIL cycle_budget: got %0d cycles expected <= 40000", cycles);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // Emulated uart_rx frame: busy for a while, then a one-cycle strobe with the byte.
  task automatic send_frame(input logic [7:0] b, input bit wait_fc, input bit pop_at_strobe);
    int n;
    if (wait_fc) begin
      n = 0;
      while (bus.rx_enable !== 1'b1 && n < 300) begin tick(); n++; end
      vectors++;
      if (bus.rx_enable !== 1'b1) begin
        errors++; $display("FAIL fc_wait: rx_enable got %b expected 1 within 300 cycles", bus.rx_enable);
        return;
      end
    end
    bus.rx_busy = 1'b1;
    repeat (FRAME_CYC) tick();
    bus.rx_busy = 1'b0; bus.rx_strobe = 1'b1; bus.rx_data = b;
    if (pop_at_strobe) bus.ready = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    if (pop_at_strobe) bus.ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    vectors++; if (level !== 5'd0)   begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    vectors++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (bus.rx_enable !== 1'b0) begin errors++; $display("FAIL reset_rx_enable: got %b expected 0", bus.rx_enable); end
    vectors++; if (idle !== 1'b0)    begin errors++; $display("FAIL reset_idle: got %b expected 0", idle); end
  endtask

  task automatic test_basic();
    enable = 1'b1; bus.ready = 1'b1;
    beat_q.delete(); max_lvl_seen = 0;
    tick();
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    tick();
    vectors++; if (beat_q.size() != 2) begin errors++; $display("FAIL basic_beats: got %0d expected 2", beat_q.size()); end
    else begin
      vectors++; if (beat_q[0] !== 8'h55) begin errors++; $display("FAIL basic_first: got %02h expected 55", beat_q[0]); end
      vectors++; if (beat_q[1] !== 8'hA3) begin errors++; $display("FAIL basic_second: got %02h expected a3", beat_q[1]); end
    end
    vectors++; if (max_lvl_seen > 1) begin errors++; $display("FAIL basic_level_max: got %0d expected <= 1", max_lvl_seen); end
  endtask

  task automatic test_flow_ctrl();
    bus.ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    vectors++; if (level !== 5'd16) begin errors++; $display("FAIL fc_full_level: got %0d expected 16", level); end
    vectors++; if (bus.rx_enable !== 1'b0) begin errors++; $display("FAIL fc_hold_rx_enable: got %b expected 0", bus.rx_enable); end
    bus.ready = 1'b1; tick(); bus.ready = 1'b0; tick();
    vectors++; if (bus.rx_enable !== 1'b1) begin errors++; $display("FAIL fc_resume_rx_enable: got %b expected 1", bus.rx_enable); end
    vectors++; if (level !== 5'd15) begin errors++; $display("FAIL fc_resume_level: got %0d expected 15", level); end
    send_frame(8'h10, 1'b1, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0);
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL fc_overrun: got %b expected 1", overrun); end
    vectors++; if (level !== 5'd16) begin errors++; $display("FAIL fc_drop_level: got %0d expected 16", level); end
  endtask

  task automatic test_full_pop();
    int n;
    clear_ovr = 1'b1; tick(); clear_ovr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun: got %b expected 0", overrun); end
    send_frame(8'h77, 1'b0, 1'b1);
    vectors++; if (level !== 5'd16) begin errors++; $display("FAIL fullpop_level: got %0d expected 16", level); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_overrun: got %b expected 0", overrun); end
    bus.rx_busy = 1'b1; repeat (FRAME_CYC) tick();
    bus.rx_busy = 1'b0; bus.rx_strobe = 1'b1; bus.rx_data = 8'h99; clear_ovr = 1'b1;
    tick();
    bus.rx_strobe = 1'b0; clear_ovr = 1'b0;
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", overrun); end
    clear_ovr = 1'b1; tick(); clear_ovr = 1'b0;
    bus.ready = 1'b1; n = 0;
    while (m_q.size() > 0 && n < 40) begin tick(); n++; end
    tick();
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
    vectors++; if (beat_q[$] !== 8'h77) begin errors++; $display("FAIL drain_tail: got %02h expected 77", beat_q[$]); end
  endtask

  task automatic test_disable_midframe();
    int beats;
    bus.ready = 1'b1;
    bus.rx_busy = 1'b1; repeat (4) tick();
    enable = 1'b0; repeat (6) tick();
    bus.rx_busy = 1'b0; bus.rx_strobe = 1'b1; bus.rx_data = 8'h3C; tick();
    bus.rx_strobe = 1'b0; repeat (2) tick();
    vectors++; if (beat_q[$] !== 8'h3C) begin errors++; $display("FAIL finish_delivered: got %02h expected 3c", beat_q[$]); end
    vectors++; if (bus.rx_enable !== 1'b0) begin errors++; $display("FAIL finish_rx_enable: got %b expected 0", bus.rx_enable); end
    beats = beat_q.size();
    send_frame(8'hEE, 1'b0, 1'b0);
    tick();
    vectors++; if (beat_q.size() != beats) begin errors++; $display("FAIL off_ignored: got %0d beats expected %0d", beat_q.size(), beats); end
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL off_level: got %0d expected 0", level); end
  endtask

  task automatic test_reset_midframe();
    enable = 1'b1; bus.ready = 1'b0; tick();
    for (int i = 0; i <= DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b0);
    bus.rx_busy = 1'b1; repeat (3) tick();
    rst = 1'b1; tick();
    vectors++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.valid); end
    vectors++; if (level !== 5'd0)   begin errors++; $display("FAIL rst_mid_level: got %0d expected 0", level); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
    rst = 1'b0; repeat (3) tick();
    bus.rx_busy = 1'b0; bus.rx_strobe = 1'b1; bus.rx_data = 8'h5A; tick();
    bus.rx_strobe = 1'b0; tick();
    vectors++; if (level !== 5'd1) begin errors++; $display("FAIL rst_mid_repush: got %0d expected 1", level); end
    bus.ready = 1'b1; repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int n;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0; bus.ready = 1'b1; n = 0;
    while (m_q.size() > 0 && n < 40) begin tick(); n++; end
    tick();
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL stream_drain: got %0d expected 0", level); end
  endtask

`ifdef UART_RX_IDLE_TIMEOUT_EN
  task automatic test_idle();
    rst = 1'b1; tick(); rst = 1'b0; enable = 1'b1; bus.ready = 1'b1;
    for (int j = 0; j < 400; j++) begin
      vectors++; if (idle !== 1'b0) begin errors++; $display("FAIL idle_early: got %b expected 0 (j=%0d)", idle, j); end
      tick();
    end
    bus.rx_busy = 1'b1; repeat (FRAME_CYC) tick();
    bus.rx_busy = 1'b0; bus.rx_strobe = 1'b1; bus.rx_data = 8'h41; tick();
    bus.rx_strobe = 1'b0;
    for (int j = 0; j < 700; j++) begin
      vectors++;
      if (idle !== (j == IDLE_T - 1)) begin
        errors++; $display("FAIL idle_pulse: got %b expected %b (cycle strobe+%0d)", idle, j == IDLE_T - 1, j + 1);
      end
      tick();
    end
  endtask
`endif

  initial begin
    vectors = 0; errors = 0; cycles = 0; max_lvl_seen = 0; rand_ready = 1'b0;
    m_ovr = 1'b0; m_st = M_OFF;
    rst = 1'b1; enable = 1'b0; clear_ovr = 1'b0;
    bus.rx_data = 8'h00; bus.rx_strobe = 1'b0; bus.rx_busy = 1'b0; bus.ready = 1'b0;
    test_reset();
    test_basic();
    test_flow_ctrl();
    test_full_pop();
    test_disable_midframe();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_RX_IDLE_TIMEOUT_EN
    test_idle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
